// File: rtl/ram_pkg.sv
// Shared types and constants for the single-port clearable RAM.
package ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam int unsigned RAM_CLR_VAL = 0;

    function automatic int unsigned lane_count(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/ram_sp_array.sv
// Pure storage: one port with per-lane write enables and a registered read.
module ram_sp_array
    import ram_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DEPTH  = 16,
    localparam int unsigned LANES = lane_count(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [LANES-1:0]  wbe,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic              rzero,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // No reset on the array so it maps onto plain memory cells.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(LANES); i++) begin
            if (we && wbe[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Read register; out-of-range reads return zero instead of aliasing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            if (rzero) begin
                rdata <= '0;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/ram_sp_clr.sv
// Single-port RAM with valid/ready requests, byte lanes and a clear sweep
// that zeroes the array after reset and whenever clr is raised.
module ram_sp_clr
    import ram_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DEPTH  = 16,
    localparam int unsigned LANES = lane_count(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] indata,
    input  logic [LANES-1:0]  be,
    output logic              ready,
    input  logic              clr,
    output logic [DATA_W-1:0] outdata,
    output logic              rvalid,
    output logic              err,
    output logic              busy
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;

    logic              acc;
    logic              in_range;
    logic              clearing;
    logic              arr_we;
    logic [LANES-1:0]  arr_wbe;
    logic [DATA_W-1:0] arr_wdata;
    logic [ADDR_W-1:0] arr_addr;

    assign clearing = (state_q == ST_CLEAR);
    assign ready    = (state_q == ST_IDLE) && !clr;
    assign acc      = en && ready;
    assign in_range = (32'(addr) < DEPTH);
    assign busy     = clearing;

    // The sweep owns the single port while clearing.
    assign arr_addr  = clearing ? clr_ptr_q : addr;
    assign arr_we    = clearing || (acc && wr && in_range);
    assign arr_wbe   = clearing ? '1 : be;
    assign arr_wdata = clearing ? DATA_W'(RAM_CLR_VAL) : indata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            ST_CLEAR: begin
                if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d   = ST_IDLE;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                end
            end
            ST_IDLE: begin
                if (clr) begin
                    state_d   = ST_CLEAR;
                    clr_ptr_d = '0;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_ptr_d = '0;
            end
        endcase
    end

    // Response strobes for accepted requests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid <= 1'b0;
            err    <= 1'b0;
        end else begin
            rvalid <= acc && !wr;
            err    <= acc && !in_range;
        end
    end

    ram_sp_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .addr  (arr_addr),
        .we    (arr_we),
        .wbe   (arr_wbe),
        .wdata (arr_wdata),
        .re    (acc && !wr),
        .rzero (!in_range),
        .rdata (outdata)
    );

endmodule

// File: tb/tb_ram_sp_clr.sv
// Self-checking bench for ram_sp_clr against an array-based reference model.
module tb_ram_sp_clr;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, wr, clr;
    logic [3:0]  addr;
    logic [15:0] indata;
    logic [1:0]  be;
    logic        ready, rvalid, err, busy;
    logic [15:0] outdata;

    logic        en2, wr2, clr2;
    logic [3:0]  addr2;
    logic [15:0] indata2;
    logic [1:0]  be2;
    logic        ready2, rvalid2, err2, busy2;
    logic [15:0] outdata2;

    int          tests = 0;
    int          fails = 0;
    logic [15:0] m16 [16];
    logic [15:0] exp_out;

    always #5 clk = ~clk;

    ram_sp_clr #(.DATA_W(16), .ADDR_W(4), .DEPTH(16)) dut (
        .clk(clk), .rst(rst), .en(en), .wr(wr), .addr(addr), .indata(indata),
        .be(be), .ready(ready), .clr(clr), .outdata(outdata), .rvalid(rvalid),
        .err(err), .busy(busy)
    );

    ram_sp_clr #(.DATA_W(16), .ADDR_W(4), .DEPTH(12)) dut12 (
        .clk(clk), .rst(rst), .en(en2), .wr(wr2), .addr(addr2), .indata(indata2),
        .be(be2), .ready(ready2), .clr(clr2), .outdata(outdata2), .rvalid(rvalid2),
        .err(err2), .busy(busy2)
    );

    function automatic void model_write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] b);
        for (int i = 0; i < 2; i++)
            if (b[i]) m16[a][8*i +: 8] = d[8*i +: 8];
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 16; i++) m16[i] = 16'h0000;
    endfunction

    task automatic drive(input logic e, input logic w, input logic [3:0] a,
                         input logic [15:0] d, input logic [1:0] b);
        en = e; wr = w; addr = a; indata = d; be = b;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        drive(1'b0, 1'b0, 4'd0, 16'h0, 2'b00);
        clr = 1'b0;
        @(negedge clk); @(negedge clk);
        tests++; if (outdata !== 16'h0000) begin fails++; $display("FAIL reset_outdata got %h want 0000", outdata); end
        tests++; if (rvalid !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL reset_strobes rvalid=%b err=%b want 0 0", rvalid, err); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL reset_busy got %b want 1", busy); end
        rst = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin @(negedge clk); n++; end
        tests++; if (n != 16) begin fails++; $display("FAIL reset_sweep_len got %0d want 16", n); end
        model_clear();
        exp_out = 16'h0000;
    endtask

    task automatic test_read_all();
        for (int a = 0; a < 16; a++) begin
            drive(1'b1, 1'b0, 4'(a), 16'h0, 2'b00);
            @(negedge clk);
            tests++;
            if (rvalid !== 1'b1 || outdata !== 16'h0000 || err !== 1'b0) begin
                fails++;
                $display("FAIL read_all a=%0d got rv=%b d=%h err=%b want 1 0000 0", a, rvalid, outdata, err);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_lanes();
        drive(1'b1, 1'b1, 4'd3, 16'hA55A, 2'b11); model_write(4'd3, 16'hA55A, 2'b11);
        @(negedge clk);
        tests++; if (rvalid !== 1'b0) begin fails++; $display("FAIL write_rvalid got %b want 0", rvalid); end
        drive(1'b1, 1'b1, 4'd3, 16'hFFFF, 2'b01); model_write(4'd3, 16'hFFFF, 2'b01);
        @(negedge clk);
        drive(1'b1, 1'b1, 4'd4, 16'h7777, 2'b00); model_write(4'd4, 16'h7777, 2'b00);
        @(negedge clk);
        drive(1'b1, 1'b0, 4'd3, 16'h0, 2'b00);
        @(negedge clk);
        tests++; if (rvalid !== 1'b1 || outdata !== 16'hA5FF) begin fails++; $display("FAIL lane_merge got rv=%b d=%h want 1 a5ff", rvalid, outdata); end
        drive(1'b1, 1'b0, 4'd4, 16'h0, 2'b00);
        @(negedge clk);
        tests++; if (outdata !== m16[4]) begin fails++; $display("FAIL be_zero_noop got %h want %h", outdata, m16[4]); end
        exp_out = m16[4];
        en = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int a = 1; a <= 3; a++) begin
            drive(1'b1, 1'b1, 4'(a), 16'(a * 16'h11), 2'b11);
            model_write(4'(a), 16'(a * 16'h11), 2'b11);
            @(negedge clk);
        end
        for (int a = 1; a <= 3; a++) begin
            drive(1'b1, 1'b0, 4'(a), 16'h0, 2'b00);
            @(negedge clk);
            tests++;
            if (rvalid !== 1'b1 || outdata !== 16'(a * 16'h11)) begin
                fails++;
                $display("FAIL b2b_read a=%0d got rv=%b d=%h want 1 %h", a, rvalid, outdata, 16'(a * 16'h11));
            end
        end
        en = 1'b0;
        @(negedge clk);
        tests++; if (rvalid !== 1'b0 || outdata !== 16'h0033) begin fails++; $display("FAIL b2b_hold got rv=%b d=%h want 0 0033", rvalid, outdata); end
        exp_out = 16'h0033;
    endtask

    task automatic test_clr_priority();
        int n;
        drive(1'b1, 1'b1, 4'd7, 16'hBEEF, 2'b11); model_write(4'd7, 16'hBEEF, 2'b11);
        @(negedge clk);
        drive(1'b1, 1'b1, 4'd7, 16'h1234, 2'b11);
        clr = 1'b1;
        #1;
        tests++; if (ready !== 1'b0) begin fails++; $display("FAIL clr_ready got %b want 0", ready); end
        @(negedge clk);
        clr = 1'b0; en = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin @(negedge clk); n++; end
        tests++; if (n != 16) begin fails++; $display("FAIL clr_sweep_len got %0d want 16", n); end
        model_clear();
        tests++; if (outdata !== exp_out) begin fails++; $display("FAIL clr_keeps_outdata got %h want %h", outdata, exp_out); end
        drive(1'b1, 1'b0, 4'd7, 16'h0, 2'b00);
        @(negedge clk);
        tests++; if (rvalid !== 1'b1 || outdata !== 16'h0000) begin fails++; $display("FAIL clr_read7 got rv=%b d=%h want 1 0000", rvalid, outdata); end
        exp_out = 16'h0000;
        en = 1'b0;
    endtask

    task automatic test_out_of_range();
        en2 = 1'b1; wr2 = 1'b1; addr2 = 4'd11; indata2 = 16'h5A5A; be2 = 2'b11;
        @(negedge clk);
        tests++; if (err2 !== 1'b0) begin fails++; $display("FAIL oob_w11_err got %b want 0", err2); end
        addr2 = 4'd13; indata2 = 16'hFFFF;
        @(negedge clk);
        tests++; if (err2 !== 1'b1 || rvalid2 !== 1'b0) begin fails++; $display("FAIL oob_w13 got err=%b rv=%b want 1 0", err2, rvalid2); end
        wr2 = 1'b0; addr2 = 4'd11;
        @(negedge clk);
        tests++; if (outdata2 !== 16'h5A5A || err2 !== 1'b0) begin fails++; $display("FAIL oob_r11a got d=%h err=%b want 5a5a 0", outdata2, err2); end
        addr2 = 4'd13;
        @(negedge clk);
        tests++; if (rvalid2 !== 1'b1 || outdata2 !== 16'h0000 || err2 !== 1'b1) begin fails++; $display("FAIL oob_r13 got rv=%b d=%h err=%b want 1 0000 1", rvalid2, outdata2, err2); end
        addr2 = 4'd11;
        @(negedge clk);
        tests++; if (rvalid2 !== 1'b1 || outdata2 !== 16'h5A5A || err2 !== 1'b0) begin fails++; $display("FAIL oob_r11b got rv=%b d=%h err=%b want 1 5a5a 0", rvalid2, outdata2, err2); end
        addr2 = 4'd1;
        @(negedge clk);
        tests++; if (outdata2 !== 16'h0000) begin fails++; $display("FAIL oob_no_alias got %h want 0000", outdata2); end
        en2 = 1'b0;
        @(negedge clk);
        tests++; if (err2 !== 1'b0 || rvalid2 !== 1'b0) begin fails++; $display("FAIL oob_idle got err=%b rv=%b want 0 0", err2, rvalid2); end
    endtask

    task automatic test_random();
        logic        e, w, exp_rv;
        logic [3:0]  a;
        logic [15:0] d;
        logic [1:0]  b;
        for (int n = 0; n < 300; n++) begin
            e = ($urandom_range(0, 9) < 7);
            w = 1'($urandom_range(0, 1));
            a = 4'($urandom_range(0, 15));
            d = 16'($urandom);
            b = 2'($urandom_range(0, 3));
            drive(e, w, a, d, b);
            if (e && !w) exp_out = m16[a];
            if (e && w) model_write(a, d, b);
            exp_rv = e && !w;
            @(negedge clk);
            tests++;
            if (rvalid !== exp_rv || outdata !== exp_out || err !== 1'b0) begin
                fails++;
                $display("FAIL random n=%0d got rv=%b d=%h err=%b want %b %h 0", n, rvalid, outdata, err, exp_rv, exp_out);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_rst_mid_sweep();
        int n;
        drive(1'b1, 1'b1, 4'd5, 16'hCAFE, 2'b11);
        @(negedge clk);
        drive(1'b1, 1'b0, 4'd5, 16'h0, 2'b00);
        @(negedge clk);
        tests++; if (outdata !== 16'hCAFE) begin fails++; $display("FAIL pre_rst_read got %h want cafe", outdata); end
        en = 1'b0; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        tests++;
        if (outdata !== 16'h0000 || rvalid !== 1'b0 || err !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL mid_rst got d=%h rv=%b err=%b busy=%b want 0000 0 0 1", outdata, rvalid, err, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin @(negedge clk); n++; end
        tests++; if (n != 16) begin fails++; $display("FAIL mid_rst_sweep_len got %0d want 16", n); end
        model_clear();
        drive(1'b1, 1'b0, 4'd5, 16'h0, 2'b00);
        @(negedge clk);
        tests++; if (rvalid !== 1'b1 || outdata !== 16'h0000) begin fails++; $display("FAIL post_rst_read got rv=%b d=%h want 1 0000", rvalid, outdata); end
        en = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        en2 = 1'b0; wr2 = 1'b0; clr2 = 1'b0; addr2 = 4'd0; indata2 = 16'h0; be2 = 2'b00;
        exp_out = 16'h0000;
        test_reset();
        test_read_all();
        test_lanes();
        test_back_to_back();
        test_clr_priority();
        test_out_of_range();
        test_random();
        test_rst_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
